// File: rtl/reg2axi_bridge_pkg.sv
// Shared types and helpers for the register-to-AXI4 bridge.
// Optional head-of-line timeout is enabled by defining REG2AXI_BRIDGE_TIMEOUT_EN.
package reg2axi_bridge_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Widest supported data path; narrower builds use the low bits.
    localparam int RSP_DATA_MAX = 64;

    typedef struct packed {
        logic                    write;
        logic                    error;
        logic [RSP_DATA_MAX-1:0] rdata;
    } rsp_t;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/reg2axi_order_fifo.sv
// One-bit-wide ordering FIFO recording the type (1=write) of each accepted request.
// Push and pop may occur in the same cycle.
module reg2axi_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg2axi_bridge.sv
// Register request stream to single-beat AXI4 master bridge, multi-outstanding, in-order responses.
// Define REG2AXI_BRIDGE_TIMEOUT_EN to build the sticky head-of-line timeout detector.
module reg2axi_bridge
    import reg2axi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [ID_WIDTH-1:0]     m_awid,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]              m_bresp,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [ID_WIDTH-1:0]     m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    output logic                    timeout
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

    // Every channel uses AXI valid/ready: a transfer happens on a rising clk edge
    // where both are high; a source never drops valid or changes payload before that.
    logic             aw_pend;
    logic             w_pend;
    logic             ar_pend;
    logic [CNT_W-1:0] outstanding;
    logic             rsp_vld;
    rsp_t             rsp_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_head;
    logic             accept;
    logic             rsp_free;
    logic             b_hs;
    logic             r_hs;
    logic             pop;
    logic             rsp_hs;

    assign req_ready = !rst && (outstanding < MAX_OUT_C) && !aw_pend && !w_pend && !ar_pend;
    assign accept    = req_valid && req_ready;
    assign rsp_free  = !rsp_vld || rsp_ready;
    assign m_bready  = !fifo_empty && fifo_head && rsp_free;
    assign m_rready  = !fifo_empty && !fifo_head && rsp_free;
    assign b_hs      = m_bvalid && m_bready;
    assign r_hs      = m_rvalid && m_rready;
    assign pop       = b_hs || r_hs;
    assign rsp_hs    = rsp_vld && rsp_ready;

    assign m_awvalid = aw_pend;
    assign m_wvalid  = w_pend;
    assign m_arvalid = ar_pend;
    assign m_awid    = '0;
    assign m_arid    = '0;
    assign m_awlen   = 8'd0;
    assign m_arlen   = 8'd0;
    assign m_awsize  = axi_size(DATA_WIDTH);
    assign m_arsize  = axi_size(DATA_WIDTH);
    assign m_awburst = AXI_BURST_INCR;
    assign m_arburst = AXI_BURST_INCR;
    assign m_wlast   = 1'b1;

    assign rsp_valid = rsp_vld;
    assign rsp_write = rsp_q.write;
    assign rsp_error = rsp_q.error;
    assign rsp_rdata = rsp_q.rdata[DATA_WIDTH-1:0];

    reg2axi_order_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_data(req_write),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_pend     <= 1'b0;
            w_pend      <= 1'b0;
            ar_pend     <= 1'b0;
            m_awaddr    <= '0;
            m_araddr    <= '0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
            outstanding <= '0;
            rsp_vld     <= 1'b0;
            rsp_q       <= '0;
        end else begin
            if (accept && req_write) begin
                m_awaddr <= req_addr;
                m_wdata  <= req_wdata;
                m_wstrb  <= req_strb;
                aw_pend  <= 1'b1;
                w_pend   <= 1'b1;
            end else begin
                if (m_awready) aw_pend <= 1'b0;
                if (m_wready)  w_pend  <= 1'b0;
            end

            if (accept && !req_write) begin
                m_araddr <= req_addr;
                ar_pend  <= 1'b1;
            end else if (m_arready) begin
                ar_pend <= 1'b0;
            end

            case ({accept, rsp_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            // A new beat may load in the same cycle the previous response is taken.
            if (b_hs) begin
                rsp_vld     <= 1'b1;
                rsp_q.write <= 1'b1;
                rsp_q.error <= (axi_resp_e'(m_bresp) != OKAY);
                rsp_q.rdata <= '0;
            end else if (r_hs) begin
                rsp_vld     <= 1'b1;
                rsp_q.write <= 1'b0;
                rsp_q.error <= (axi_resp_e'(m_rresp) != OKAY);
                rsp_q.rdata <= RSP_DATA_MAX'(m_rdata);
            end else if (rsp_hs) begin
                rsp_vld <= 1'b0;
            end
        end
    end

`ifdef REG2AXI_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;
    logic            to_flag;
    logic            head_arrived;

    assign head_arrived = fifo_head ? m_bvalid : m_rvalid;
    assign timeout      = to_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (pop) begin
                to_cnt <= '0;
            end else if (!fifo_empty && !head_arrived && (to_cnt != TO_LIMIT)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (to_cnt == TO_LIMIT) to_flag <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // IDs are always zero and every beat is last, so these inputs carry no information.
    logic unused_inputs;
    assign unused_inputs = ^{m_bid, m_rid, m_rlast, fifo_full, rsp_q};

endmodule

// File: tb/tb_reg2axi_bridge.sv
// Directed self-checking bench for reg2axi_bridge; the AXI slave is driven by hand.
// Timeout expectations follow REG2AXI_BRIDGE_TIMEOUT_EN.
module tb_reg2axi_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          m_awvalid, m_awready;
    logic [AW-1:0] m_awaddr;
    logic [IW-1:0] m_awid;
    logic [7:0]    m_awlen;
    logic [2:0]    m_awsize;
    logic [1:0]    m_awburst;
    logic          m_wvalid, m_wready;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_wlast;
    logic          m_bvalid, m_bready;
    logic [IW-1:0] m_bid;
    logic [1:0]    m_bresp;
    logic          m_arvalid, m_arready;
    logic [AW-1:0] m_araddr;
    logic [IW-1:0] m_arid;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_rvalid, m_rready;
    logic [IW-1:0] m_rid;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          timeout;

    int n_cmp = 0;
    int n_err = 0;

    reg2axi_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        #1;
        for (int n = 0; n < 50 && !done; n++) begin
            if (req_ready) done = 1'b1;
            cyc();
        end
        req_valid = 1'b0;
        check("req_accepted", 64'(done), 64'd1);
    endtask

    logic exp_timeout;

    initial begin
`ifdef REG2AXI_BRIDGE_TIMEOUT_EN
        exp_timeout = 1'b1;
`else
        exp_timeout = 1'b0;
`endif
        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_strb = '0;
        rsp_ready = 0;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bid = '0; m_bresp = 2'b00;
        m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b1;

        // reset state and constant outputs
        repeat (3) cyc();
        check("ready_in_reset", 64'(req_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_awvalid", 64'(m_awvalid), 64'd0);
        check("reset_wvalid", 64'(m_wvalid), 64'd0);
        check("reset_arvalid", 64'(m_arvalid), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("reset_bready", 64'(m_bready), 64'd0);
        check("reset_rready", 64'(m_rready), 64'd0);
        check("reset_timeout", 64'(timeout), 64'd0);
        check("awlen", 64'(m_awlen), 64'd0);
        check("awsize", 64'(m_awsize), 64'd2);
        check("arsize", 64'(m_arsize), 64'd2);
        check("awburst", 64'(m_awburst), 64'd1);
        check("arburst", 64'(m_arburst), 64'd1);
        check("wlast", 64'(m_wlast), 64'd1);
        check("awid", 64'(m_awid), 64'd0);

        // single write, AW and W handshaken on different cycles
        send_req(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        check("wr_awvalid", 64'(m_awvalid), 64'd1);
        check("wr_wvalid", 64'(m_wvalid), 64'd1);
        check("wr_awaddr", 64'(m_awaddr), 64'h100);
        check("wr_wdata", 64'(m_wdata), 64'hDEADBEEF);
        check("wr_wstrb", 64'(m_wstrb), 64'hF);
        check("wr_busy", 64'(req_ready), 64'd0);
        m_awready = 1'b1;
        cyc();
        check("wr_aw_done", 64'(m_awvalid), 64'd0);
        check("wr_w_held", 64'(m_wvalid), 64'd1);
        check("wr_busy_w", 64'(req_ready), 64'd0);
        m_awready = 1'b0;
        m_wready  = 1'b1;
        cyc();
        check("wr_w_done", 64'(m_wvalid), 64'd0);
        check("wr_ready_again", 64'(req_ready), 64'd1);
        m_wready = 1'b0;
        m_bvalid = 1'b1;
        m_bresp  = 2'b00;
        #1;
        check("wr_bready", 64'(m_bready), 64'd1);
        cyc();
        m_bvalid = 1'b0;
        check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        check("wr_rsp_write", 64'(rsp_write), 64'd1);
        check("wr_rsp_error", 64'(rsp_error), 64'd0);
        check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        rsp_ready = 1'b1;
        cyc();
        check("wr_rsp_taken", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;

        // four reads fill the outstanding window; R held back
        m_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_req(1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'h0);
            check("rd_arvalid", 64'(m_arvalid), 64'd1);
            check("rd_araddr", 64'(m_araddr), 64'(32'h200 + 32'(4 * i)));
        end
        cyc();
        check("rd_ar_done", 64'(m_arvalid), 64'd0);
        check("rd_full", 64'(req_ready), 64'd0);
        repeat (15) cyc();
        check("rd_full_wait", 64'(req_ready), 64'd0);
        m_rvalid  = 1'b1;
        m_rdata   = 32'h1000;
        rsp_ready = 1'b1;
        #1;
        check("rd_rready", 64'(m_rready), 64'd1);
        cyc();
        check("rd0_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rd0_rsp_write", 64'(rsp_write), 64'd0);
        check("rd0_rdata", 64'(rsp_rdata), 64'h1000);
        check("rd_full_before_rsp", 64'(req_ready), 64'd0);
        for (int i = 1; i < 4; i++) begin
            m_rdata = 32'h1000 + 32'(i);
            cyc();
            check("rd_ready_after_rsp", 64'(req_ready), 64'd1);
            check("rdn_rdata", 64'(rsp_rdata), 64'(32'h1000 + 32'(i)));
        end
        m_rvalid = 1'b0;
        cyc();
        check("rd_drained", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;

        // write then read, R arrives before B and must wait
        m_awready = 1'b1;
        m_wready  = 1'b1;
        send_req(1'b1, 32'h300, 32'h11112222, 4'h3);
        check("wr3_awaddr", 64'(m_awaddr), 64'h300);
        send_req(1'b0, 32'h304, 32'h0, 4'h0);
        cyc();
        check("ord_ar_done", 64'(m_arvalid), 64'd0);
        m_rvalid = 1'b1;
        m_rdata  = 32'hCAFEF00D;
        #1;
        check("ord_rready_blocked", 64'(m_rready), 64'd0);
        repeat (3) cyc();
        check("ord_no_rsp", 64'(rsp_valid), 64'd0);
        check("ord_rready_still", 64'(m_rready), 64'd0);
        m_bvalid = 1'b1;
        m_bresp  = 2'b00;
        #1;
        check("ord_bready", 64'(m_bready), 64'd1);
        cyc();
        m_bvalid = 1'b0;
        check("ord_first_valid", 64'(rsp_valid), 64'd1);
        check("ord_first_write", 64'(rsp_write), 64'd1);
        check("ord_rready_bp", 64'(m_rready), 64'd0);
        rsp_ready = 1'b1;
        #1;
        check("ord_rready_go", 64'(m_rready), 64'd1);
        cyc();
        m_rvalid = 1'b0;
        check("ord_second_valid", 64'(rsp_valid), 64'd1);
        check("ord_second_write", 64'(rsp_write), 64'd0);
        check("ord_second_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
        check("ord_second_error", 64'(rsp_error), 64'd0);
        cyc();
        check("ord_drained", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;
        m_awready = 1'b0;
        m_wready  = 1'b0;

        // read with SLVERR
        send_req(1'b0, 32'h400, 32'h0, 4'h0);
        cyc();
        m_rvalid  = 1'b1;
        m_rresp   = 2'b10;
        m_rdata   = 32'h5A5A5A5A;
        rsp_ready = 1'b1;
        cyc();
        m_rvalid = 1'b0;
        m_rresp  = 2'b00;
        check("err_rsp_error", 64'(rsp_error), 64'd1);
        check("err_rsp_rdata", 64'(rsp_rdata), 64'h5A5A5A5A);
        cyc();
        check("err_drained", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;

        // response backpressure with two reads pending
        send_req(1'b0, 32'h500, 32'h0, 4'h0);
        send_req(1'b0, 32'h504, 32'h0, 4'h0);
        cyc();
        m_rvalid = 1'b1;
        m_rdata  = 32'hA0A0A0A0;
        cyc();
        m_rdata = 32'hB0B0B0B0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_valid_held", 64'(rsp_valid), 64'd1);
            check("bp_rdata_held", 64'(rsp_rdata), 64'hA0A0A0A0);
            check("bp_rready_low", 64'(m_rready), 64'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_rready_go", 64'(m_rready), 64'd1);
        cyc();
        m_rvalid = 1'b0;
        check("bp_second_valid", 64'(rsp_valid), 64'd1);
        check("bp_second_rdata", 64'(rsp_rdata), 64'hB0B0B0B0);
        cyc();
        check("bp_drained", 64'(rsp_valid), 64'd0);
        check("bp_ready_idle", 64'(req_ready), 64'd1);
        rsp_ready = 1'b0;

        // withheld write response, then reset mid-transaction
        send_req(1'b1, 32'h600, 32'h12345678, 4'hF);
        repeat (5) cyc();
        check("to_early", 64'(timeout), 64'd0);
        repeat (20) cyc();
        check("to_late", 64'(timeout), 64'(exp_timeout));
        check("to_aw_pending", 64'(m_awvalid), 64'd1);
        rst = 1'b1;
        cyc();
        check("rst_awvalid", 64'(m_awvalid), 64'd0);
        check("rst_wvalid", 64'(m_wvalid), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_bready", 64'(m_bready), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
